// File: rtl/ah_arb_request_agent.sv
// Requester-side agent for the 8-way weighted round-robin arbiter.
// Keeps a saturating pending count per client and presents req = (cnt != 0).
// Consumes the arbiter's registered one-hot grant and reports each accepted
// grant one cycle later as an encoded index with a valid strobe.
// Malformed grants are flagged in sticky error bits.
module ah_arb_request_agent #(
  parameter int N     = 8,
  parameter int IDW   = 3,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   post,
  output logic [N-1:0]   req,
  input  logic [N-1:0]   grant,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   full,
  input  logic           clr_err,
  output logic [N-1:0]   ovf,
  output logic           err_spur,
  output logic           err_multi
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt [N];

  logic           g_multi;
  logic           g_one;
  logic [IDW-1:0] g_idx;
  logic           g_accept;
  logic           g_spur;
  logic [N-1:0]   dec;
  logic [N-1:0]   ovf_set;

  // Classify the grant vector and pick out the single granted client.
  // x & (x-1) clears the lowest set bit, so a nonzero result means 2+ bits.
  always_comb begin
    g_multi = |(grant & (grant - ONE_N));
    g_one   = (grant != '0) && !g_multi;
    g_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) g_idx = IDW'(i);
    end
    g_accept = g_one && (cnt[g_idx] != '0);
    g_spur   = g_one && (cnt[g_idx] == '0);
    dec      = g_accept ? grant : '0;
  end

  // Per-client overflow detect: a post that cannot be absorbed is dropped.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < N; i++) begin
      ovf_set[i] = post[i] && !dec[i] && (cnt[i] == CNT_MAX);
    end
  end

  // Saturating pending counters; post and accepted grant together cancel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        case ({post[i], dec[i]})
          2'b10:   if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
          2'b01:   if (cnt[i] != '0)      cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // req and full decode the registered counters only.
  always_comb begin
    req  = '0;
    full = '0;
    for (int i = 0; i < N; i++) begin
      req[i]  = (cnt[i] != '0);
      full[i] = (cnt[i] == CNT_MAX);
    end
  end

  // Grant report: one-cycle pulse per accepted grant; id holds between reports.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      gnt_valid <= g_accept;
      if (g_accept) gnt_id <= g_idx;
    end
  end

  // Sticky error flags; a new set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf       <= '0;
      err_spur  <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      ovf       <= ovf_set | (ovf & {N{~clr_err}});
      err_spur  <= g_spur | (err_spur & ~clr_err);
      err_multi <= g_multi | (err_multi & ~clr_err);
    end
  end

endmodule

// File: tb/tb_ah_arb_request_agent.sv
// Bench for ah_arb_request_agent: directed scenarios followed by random
// post/grant traffic, all checked against a behavioural model of the
// pending counts, grant acceptance and sticky flags.
module tb_ah_arb_request_agent;

  localparam int N    = 8;
  localparam int MAXC = 15;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] post;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         gnt_valid;
  logic [2:0]   gnt_id;
  logic [N-1:0] full;
  logic         clr_err;
  logic [N-1:0] ovf;
  logic         err_spur;
  logic         err_multi;

  ah_arb_request_agent #(.N(8), .IDW(3), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .post(post), .req(req), .grant(grant),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .full(full), .clr_err(clr_err),
    .ovf(ovf), .err_spur(err_spur), .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int         m_cnt [N];
  logic [N-1:0] m_ovf;
  logic       m_spur, m_multi, m_valid;
  int         m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ovf = '0; m_spur = 0; m_multi = 0; m_valid = 0; m_id = 0;
  endtask

  task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] g, input logic c);
    int nset, gi, acc;
    logic [N-1:0] oset;
    nset = $countones(g);
    acc = -1; gi = -1; oset = '0;
    for (int i = 0; i < N; i++) if (g[i]) gi = i;
    if (nset == 1) begin
      if (m_cnt[gi] > 0) acc = gi;
    end
    m_spur  = ((nset == 1) && (acc < 0)) || (m_spur && !c);
    m_multi = (nset > 1) || (m_multi && !c);
    for (int i = 0; i < N; i++) begin
      if (p[i] && acc != i) begin
        if (m_cnt[i] == MAXC) oset[i] = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1;
      end else if (!p[i] && acc == i) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
    m_ovf = oset | (c ? '0 : m_ovf);
    m_valid = (acc >= 0);
    if (acc >= 0) m_id = acc;
  endtask

  function automatic logic [N-1:0] m_req();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_cnt[i] != 0);
    return r;
  endfunction

  function automatic logic [N-1:0] m_full();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_cnt[i] == MAXC);
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".req"},       32'(req),       32'(m_req()));
    chk({tag, ".full"},      32'(full),      32'(m_full()));
    chk({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
    chk({tag, ".err_spur"},  32'(err_spur),  32'(m_spur));
    chk({tag, ".err_multi"}, 32'(err_multi), 32'(m_multi));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_valid));
    if (m_valid) chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(m_id));
  endtask

  // Apply one cycle of inputs, clock it, then check 1ns after the edge.
  task automatic step(input string tag, input logic [N-1:0] p, input logic [N-1:0] g,
                      input logic c);
    post = p; grant = g; clr_err = c;
    @(posedge clk);
    model_step(p, g, c);
    #1;
    post = '0; grant = '0; clr_err = 1'b0;
    check_all(tag);
  endtask

  // Assert reset between edges and check that outputs drop at once.
  task automatic mid_reset(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk({tag, ".req_async"},   32'(req),       32'(0));
    chk({tag, ".valid_async"}, 32'(gnt_valid), 32'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    logic [N-1:0] p, g;
    logic c;
    int r, k;
    model_reset();
    rstn = 1'b0; post = 8'hFF; grant = '0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    post = '0;
    rstn = 1'b1;

    step("post3", 8'h08, 8'h00, 0);
    chk("post3.req_exact", 32'(req), 32'h08);
    step("drain3", 8'h00, 8'h08, 0);
    step("drain3_rpt", 8'h00, 8'h00, 0);

    repeat (3) step("post5", 8'h20, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      step("g5", 8'h00, 8'h20, 0);
      chk("g5.id_exact", 32'(gnt_id), 32'd5);
      step("g5_idle", 8'h00, 8'h00, 0);
    end
    chk("g5.req_low", 32'(req[5]), 32'd0);

    step("sim_pre", 8'h04, 8'h00, 0);
    step("sim", 8'h04, 8'h04, 0);
    chk("sim.req2", 32'(req[2]), 32'd1);
    chk("sim.id2", 32'(gnt_id), 32'd2);
    step("sim_drain", 8'h00, 8'h04, 0);

    for (int i = 0; i < 16; i++) step("sat", 8'h01, 8'h00, 0);
    chk("sat.ovf0", 32'(ovf[0]), 32'd1);
    chk("sat.full0", 32'(full[0]), 32'd1);
    step("sat_clr", 8'h00, 8'h00, 1);
    step("sat_dec", 8'h00, 8'h01, 0);
    chk("sat.full_drop", 32'(full[0]), 32'd0);

    step("spur", 8'h00, 8'h80, 0);
    chk("spur.flag", 32'(err_spur), 32'd1);
    step("multi_pre", 8'h02, 8'h00, 0);
    step("multi", 8'h00, 8'h03, 0);
    chk("multi.flag", 32'(err_multi), 32'd1);
    step("clr", 8'h00, 8'h00, 1);
    chk("clr.flags", 32'({err_spur, err_multi}), 32'd0);
    step("clr_set", 8'h00, 8'h80, 1);

    repeat (4) step("mid_post", 8'h02, 8'h00, 0);
    step("mid_grant", 8'h00, 8'h02, 0);
    mid_reset("midrst");
    step("after_rst", 8'h00, 8'h00, 0);
    chk("after_rst.req", 32'(req), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom));
      r = $urandom_range(0, 19);
      if (r < 12) begin
        k = $urandom_range(0, N - 1);
        for (int t = 0; t < N; t++) if (m_cnt[(k + t) % N] != 0) begin k = (k + t) % N; break; end
        g = 8'(1 << k);
      end else if (r < 16) g = '0;
      else if (r < 18) g = 8'(1 << $urandom_range(0, N - 1));
      else g = 8'($urandom);
      c = ($urandom_range(0, 15) == 0);
      step("rand", p, g, c);
      if ($urandom_range(0, 499) == 0) mid_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
